// File: rtl/ram_timing_pkg.sv
// Shared types and timing defaults for the DRAM refresh/access arbiter.
// One-hot state encoding and a helper that sizes the phase timer.
package ram_timing_pkg;

    typedef enum logic [6:0] {
        S_IDLE     = 7'b0000001,
        S_ACC_RAS  = 7'b0000010,
        S_ACC_CAS  = 7'b0000100,
        S_ACC_HOLD = 7'b0001000,
        S_REF_CAS  = 7'b0010000,
        S_REF_RAS  = 7'b0100000,
        S_PRE      = 7'b1000000
    } state_e;

    localparam int TRCD_DEF = 2;
    localparam int TCAS_DEF = 2;
    localparam int TRAS_DEF = 4;
    localparam int TRP_DEF  = 2;

    // Width needed to hold the longest phase count minus one.
    function automatic int TMR_W(input int a, input int b,
                                 input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ram_phase_timer.sv
// Loadable saturating down-counter that times each DRAM phase.
// zero_o marks the final cycle of a phase; last_o marks the one before it.
module ram_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;

    // Load on phase entry, otherwise count down and stick at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/ram_refresh_arbiter.sv
// Shares the DRAM array between CPU bus cycles and CBR refresh.
// Every DRAM pin and handshake output comes straight from a flop.
module ram_refresh_arbiter
    import ram_timing_pkg::*;
#(
    parameter int TRCD = TRCD_DEF,
    parameter int TCAS = TCAS_DEF,
    parameter int TRAS = TRAS_DEF,
    parameter int TRP  = TRP_DEF
) (
    input  logic FCLK,
    input  logic RST,
    input  logic CACT,
    input  logic RAMCS,
    input  logic RAMWR,
    input  logic RefReq,
    input  logic RefUrgent,
    output logic RefAck,
    output logic RAMReady,
    output logic RASEL,
    output logic nRAS,
    output logic nCAS,
    output logic nWE
);

    localparam int W = TMR_W(TRCD, TCAS, TRAS, TRP);

    state_e       state_q, state_d;
    logic         load;
    logic [W-1:0] load_val;
    logic         tmr_zero;
    logic         tmr_last;
    logic         ready_d;
    logic         wr_q;
    logic         ras_n_q, cas_n_q, we_n_q, rasel_q;
    logic         ack_q, ready_q;

    ram_phase_timer #(.W(W)) u_timer (
        .clk_i   (FCLK),
        .rst_i   (RST),
        .load_i  (load),
        .value_i (load_val),
        .zero_o  (tmr_zero),
        .last_o  (tmr_last)
    );

    // Arbitration and phase sequencing; timer reloads on every state change.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        ready_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (RefUrgent)
                    state_d = S_REF_CAS;
                else if (CACT && RAMCS)
                    state_d = S_ACC_RAS;
                else if (RefReq && !CACT)
                    state_d = S_REF_CAS;
            end
            S_ACC_RAS: begin
                if (!CACT)
                    state_d = S_PRE;
                else if (tmr_zero)
                    state_d = S_ACC_CAS;
            end
            S_ACC_CAS: begin
                if (!CACT)
                    state_d = S_PRE;
                else if (tmr_zero)
                    state_d = S_ACC_HOLD;
            end
            S_ACC_HOLD: begin
                if (!CACT)
                    state_d = S_PRE;
            end
            S_REF_CAS: state_d = S_REF_RAS;
            S_REF_RAS: begin
                if (tmr_zero)
                    state_d = S_PRE;
            end
            S_PRE: begin
                if (tmr_zero)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        load = (state_d != state_q);
        unique case (state_d)
            S_ACC_RAS: load_val = W'(TRCD - 1);
            S_ACC_CAS: load_val = W'(TCAS - 1);
            S_REF_RAS: load_val = W'(TRAS - 1);
            S_PRE:     load_val = W'(TRP - 1);
            default:   load_val = '0;
        endcase
        if (state_d == S_ACC_CAS)
            ready_d = load ? (TCAS == 1) : tmr_last;
    end

    // State and pin registers; pins are decoded from the next state.
    always_ff @(posedge FCLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
            we_n_q  <= 1'b1;
            rasel_q <= 1'b1;
            ack_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && state_d == S_ACC_RAS)
                wr_q <= RAMWR;
            ras_n_q <= !(state_d inside {S_ACC_RAS, S_ACC_CAS,
                                         S_ACC_HOLD, S_REF_RAS});
            cas_n_q <= !(state_d inside {S_ACC_CAS, S_ACC_HOLD,
                                         S_REF_CAS, S_REF_RAS});
            we_n_q  <= !((state_d inside {S_ACC_CAS, S_ACC_HOLD}) && wr_q);
            rasel_q <= !(state_d inside {S_ACC_CAS, S_ACC_HOLD});
            ack_q   <= (state_q == S_REF_CAS) && (state_d == S_REF_RAS);
            ready_q <= ready_d;
        end
    end

    assign nRAS     = ras_n_q;
    assign nCAS     = cas_n_q;
    assign nWE      = we_n_q;
    assign RASEL    = rasel_q;
    assign RefAck   = ack_q;
    assign RAMReady = ready_q;

endmodule
